ws2811_frame_ctrl: RTL and testbench
====================================

Name: ws2811_frame_ctrl

Overview:
- Frame sequencer for the WS2811 pixel chain.
- Fetches 24-bit pixel words from a pixel buffer and serializes them MSB-first onto the LED data line. Each bit occupies one 40-cycle slot from the ws2811 bit-timing generator.
- Appends a latch gap and reports completion.
- Sits between the pixel buffer and the bit-timing generator; top level drives start from the refresh logic.

Parameters:
- PIX_W, 24, bits per pixel word, sent MSB first.
- MAX_PIX, 256, maximum pixels per frame.
- ADDR_W, 8, pixel buffer address width, equal to clog2(MAX_PIX).
- LATCH_SLOTS, 24, bit slots of forced-low output after the last bit. 24 x 2.5 us = 60 us, which exceeds the 50 us latch requirement.

Ports:
- clk  in  1  system clock, 16 MHz
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to send a frame
- num_pixels  in  ADDR_W+1  pixel count, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of latch gap
- pix_rd  out  1  pixel buffer read strobe
- pix_addr  out  ADDR_W  pixel buffer read address
- pix_data  in  PIX_W  read data, valid exactly 1 cycle after pix_rd
- bit_stb  in  1  high for the first cycle of each bit slot
- slot_hi0  in  1  '0'-code high-phase level: high for cycles 0..7 of a slot
- slot_hi1  in  1  '1'-code high-phase level: high for cycles 0..19 of a slot
- dout  out  1  LED data line

Behaviour:
- Reset values: busy=0, done=0, pix_rd=0, pix_addr=0, dout=0. Internal state goes to IDLE.
- States: IDLE, FETCH, ARM, SEND, LATCH.
- IDLE:
  - start with num_pixels in 1..MAX_PIX: latch the count, set busy=1, go to FETCH.
  - start with num_pixels=0: no fetch, no output; done pulses on the next cycle; busy stays 0.
  - num_pixels > MAX_PIX: clamped to MAX_PIX.
- FETCH: pix_rd=1 for one cycle with pix_addr=0. Capture pix_data on the following cycle into the prefetch register, then go to ARM.
- ARM: wait for bit_stb. At that stb, move prefetch into the shift register and go to SEND. The first slot begins on this stb.
- SEND:
  - On every bit_stb, the current bit is the shift register MSB; shift left.
  - Within a pixel: on the stb of bit 0, issue pix_rd for the next address. Capture its data into prefetch one cycle later. No read is issued after the last pixel.
  - After the 24th bit of the last pixel, go to LATCH on the next stb.
- dout:
  - Registered; equals (bit ? slot_hi1 : slot_hi0) delayed one cycle during SEND.
  - Result: a '1' code is 20 cycles high then 20 low; a '0' code is 8 high then 32 low.
  - Slot boundaries are shifted one cycle after bit_stb.
  - dout=0 in IDLE, FETCH, ARM and LATCH.
- LATCH: count LATCH_SLOTS bit_stb pulses. On the stb completing the count: done=1 for one cycle, busy=0, go to IDLE.
- start while busy=1 is ignored with no side effects.
- start in the same cycle as done is accepted.
- Reset mid-frame: dout forced to 0 asynchronously, pixel position discarded. No partial resume.
- bit_stb in FETCH has no effect. Prefetch always completes within 2 cycles, well inside a 40-cycle slot.
- Frame length: N*24 + LATCH_SLOTS slots, plus 2..41 cycles of ARM alignment.

Decomposition:
- Shared package ws2811_pkg:
  - timing constants CYC_COUNT=40, ZR_CYC_HI=8, ON_CYC_HI=20;
  - PIX_W;
  - state enum.
- One natural sub-module: ws2811_shift, holding the 24-bit shift register, prefetch register and bit counter. Load/shift are driven by the FSM.
- The FSM, address counter and latch counter stay in ws2811_frame_ctrl.

Test Plan:
- One pixel 0x800001, num_pixels=1, generator free-running:
  - exactly one pix_rd at addr 0;
  - dout pulse widths: 20, then 22 x 8, then 20 cycles, at 40-cycle period;
  - then 24 slots low;
  - done pulses once; busy falls with done.
- Three pixels, buffer {0xFF0000, 0x00FF00, 0x0000FF}:
  - pix_rd at addr 0, 1, 2 in order, each ≥1 slot before it is needed;
  - 72 slots matching the bit pattern;
  - no fourth read.
- start re-asserted mid-SEND of the three-pixel frame -> ignored; single done, identical waveform.
- num_pixels=0 -> no pix_rd; dout stays 0; done one cycle after start; busy never high.
- rst asserted at slot 30 of the three-pixel frame -> dout=0 same cycle; IDLE. A new start of one pixel replays from addr 0 correctly.
- start in the same cycle as done -> second frame begins; gap between frames is the latch plus ARM only; no lost or duplicated pixels.

Source files
------------

// File: rtl/ws2811_pkg.sv
// ws2811_pkg: shared constants and types for the WS2811 frame sequencer.
//   CYC_COUNT / ZR_CYC_HI / ON_CYC_HI : bit-slot timing (cycles per slot,
//                                       high time of a '0' and a '1' code)
//   PIX_W, BIT_IDX_W                  : pixel word width and bit index width
//   state_t                           : frame sequencer states
package ws2811_pkg;

  localparam int CYC_COUNT = 40;
  localparam int ZR_CYC_HI = 8;
  localparam int ON_CYC_HI = 20;

  localparam int PIX_W     = 24;
  localparam int BIT_IDX_W = $clog2(PIX_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ARM   = 3'd2,
    ST_SEND  = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

endpackage

// File: rtl/ws2811_shift.sv
// ws2811_shift: pixel datapath for the frame sequencer.
// Holds the prefetch register, the MSB-first shift register, the bit that
// owns the current slot and the index of the bit the next strobe will send.
//   clk, rst     : clock, asynchronous active-high reset
//   cap_i        : capture pix_data_i into the prefetch register
//   pix_data_i   : pixel word from the buffer
//   load_i       : slot strobe that starts a new pixel (sends prefetch MSB)
//   shift_i      : slot strobe inside a pixel (sends shift register MSB)
//   slot_bit_o   : bit that the strobe of this cycle starts (valid on load/shift)
//   cur_bit_o    : bit owning the slot currently on the line
//   bit_idx_o    : index of the bit the next strobe sends; 0 = pixel boundary
module ws2811_shift
  import ws2811_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_i,
  input  logic [PIX_W-1:0]     pix_data_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  output logic                 slot_bit_o,
  output logic                 cur_bit_o,
  output logic [BIT_IDX_W-1:0] bit_idx_o
);

  localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(PIX_W - 1);

  logic [PIX_W-1:0]     pre_q;
  logic [PIX_W-1:0]     sh_q;
  logic [PIX_W-1:0]     word;
  logic                 cur_q;
  logic [BIT_IDX_W-1:0] idx_q;
  logic [BIT_IDX_W-1:0] idx_d;

  // A load sends bit 0 straight from the prefetch register, so the shift
  // register only ever holds the bits still to go.
  always_comb begin
    word = load_i ? pre_q : sh_q;
    if (load_i) begin
      idx_d = IDX_ONE;
    end else if (idx_q == IDX_LAST) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + IDX_ONE;
    end
  end

  assign slot_bit_o = word[PIX_W-1];
  assign cur_bit_o  = cur_q;
  assign bit_idx_o  = idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      sh_q  <= '0;
      cur_q <= 1'b0;
      idx_q <= '0;
    end else begin
      if (cap_i) begin
        pre_q <= pix_data_i;
      end
      if (load_i || shift_i) begin
        sh_q  <= {word[PIX_W-2:0], 1'b0};
        cur_q <= word[PIX_W-1];
        idx_q <= idx_d;
      end
    end
  end

endmodule

// File: rtl/ws2811_frame_ctrl.sv
// ws2811_frame_ctrl: frame sequencer for a WS2811 pixel chain.
// Fetches pixel words, serialises them MSB first into 40-cycle bit slots
// supplied by the bit-timing generator, then holds the line low for
// LATCH_SLOTS slots and pulses done.
//   clk, rst            : clock, asynchronous active-high reset
//   start, num_pixels   : frame request and pixel count (clamped to MAX_PIX)
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
//   pix_rd, pix_addr    : pixel buffer read strobe and address
//   pix_data            : read data, valid the cycle after pix_rd
//   bit_stb             : first cycle of each bit slot
//   slot_hi0, slot_hi1  : high-phase level of a '0' / '1' code
//   dout                : LED data line
//   dbg_state           : current sequencer state
//
// Handshake: pix_rd is a single-cycle request with no back-pressure; the
// buffer must present pix_data on the cycle after pix_rd is high.
module ws2811_frame_ctrl
  import ws2811_pkg::*;
#(
  parameter int MAX_PIX     = 256,
  parameter int ADDR_W      = 8,
  parameter int LATCH_SLOTS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_pixels,
  output logic              busy,
  output logic              done,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              bit_stb,
  input  logic              slot_hi0,
  input  logic              slot_hi1,
  output logic              dout,
  output state_t            dbg_state
);

  localparam int LATCH_W = $clog2(LATCH_SLOTS);
  localparam logic [ADDR_W:0]    MAX_CNT    = MAX_PIX[ADDR_W:0];
  localparam logic [ADDR_W:0]    CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LATCH_W-1:0] LATCH_ONE  = LATCH_W'(1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_SLOTS - 1);

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dout_q, dout_d;
  logic                rd_pend_q;
  logic [ADDR_W:0]     cnt_q, cnt_d;          // pixels in this frame
  logic [ADDR_W:0]     pix_cnt_q, pix_cnt_d;  // pixels loaded so far
  logic [LATCH_W-1:0]  latch_cnt_q, latch_cnt_d;

  logic                load;
  logic                shift;
  logic                rd;
  logic [ADDR_W-1:0]   rd_addr;
  logic                slot_bit;
  logic                cur_bit;
  logic [BIT_IDX_W-1:0] bit_idx;

  ws2811_shift u_shift (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (rd_pend_q),
    .pix_data_i (pix_data),
    .load_i     (load),
    .shift_i    (shift),
    .slot_bit_o (slot_bit),
    .cur_bit_o  (cur_bit),
    .bit_idx_o  (bit_idx)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    pix_cnt_d   = pix_cnt_q;
    latch_cnt_d = latch_cnt_q;
    load        = 1'b0;
    shift       = 1'b0;
    rd          = 1'b0;
    rd_addr     = '0;
    dout_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_pixels == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d     = (num_pixels > MAX_CNT) ? MAX_CNT : num_pixels;
            pix_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      // First cycle issues the read of pixel 0, second cycle captures it.
      ST_FETCH: begin
        if (!rd_pend_q) begin
          rd = 1'b1;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (bit_stb) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_stb) begin
          if (bit_idx != '0) begin
            shift = 1'b1;
          end else if (pix_cnt_q != cnt_q) begin
            load = 1'b1;
          end else begin
            // This strobe opens the first low latch slot.
            latch_cnt_d = '0;
            state_d     = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (bit_stb) begin
          if (latch_cnt_q == LATCH_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            latch_cnt_d = latch_cnt_q + LATCH_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Consuming a prefetched pixel immediately requests the next one, a full
    // pixel time ahead of its use.
    if (load) begin
      pix_cnt_d = pix_cnt_q + CNT_ONE;
      if (pix_cnt_d < cnt_q) begin
        rd      = 1'b1;
        rd_addr = pix_cnt_d[ADDR_W-1:0];
      end
    end

    if (load || shift) begin
      dout_d = slot_bit ? slot_hi1 : slot_hi0;
    end else if (state_q == ST_SEND && !bit_stb) begin
      dout_d = cur_bit ? slot_hi1 : slot_hi0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      cnt_q       <= '0;
      pix_cnt_q   <= '0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      rd_pend_q   <= rd;
      cnt_q       <= cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dout      = dout_q;
  assign pix_rd    = rd;
  assign pix_addr  = rd_addr;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
module tb_ws2811_frame_ctrl;
  import ws2811_pkg::*;

  localparam int MAX_PIX     = 256;
  localparam int ADDR_W      = 8;
  localparam int LATCH_SLOTS = 24;

  typedef struct {
    int start_cyc;
    int npix;
  } frame_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_pixels = '0;
  logic              busy, done, pix_rd, dout;
  logic [ADDR_W-1:0] pix_addr;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              bit_stb, slot_hi0, slot_hi1;
  state_t            dbg_state;

  ws2811_frame_ctrl #(
    .MAX_PIX(MAX_PIX), .ADDR_W(ADDR_W), .LATCH_SLOTS(LATCH_SLOTS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
    .busy(busy), .done(done), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .pix_data(pix_data), .bit_stb(bit_stb), .slot_hi0(slot_hi0),
    .slot_hi1(slot_hi1), .dout(dout), .dbg_state(dbg_state)
  );

  // Free-running bit-timing generator model.
  logic [5:0] slot_cnt;
  always @(posedge clk) slot_cnt <= (int'(slot_cnt) == CYC_COUNT - 1) ? 6'd0 : slot_cnt + 6'd1;
  assign bit_stb  = (slot_cnt == 6'd0);
  assign slot_hi0 = (int'(slot_cnt) < ZR_CYC_HI);
  assign slot_hi1 = (int'(slot_cnt) < ON_CYC_HI);

  // Pixel buffer model: data one cycle after the read strobe.
  logic [PIX_W-1:0] mem [MAX_PIX];
  always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];

  // ---------------- scoreboard ----------------
  logic              exp_bit_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  frame_t            exp_done_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(string name, longint act, longint lo, longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic fail_now(string name, longint act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=%0d expected none (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: a frame is the first min(n,MAX_PIX) buffer words,
  // each sent MSB first, read in address order.
  task automatic push_expect(int n, int start_cyc);
    int     ne;
    frame_t f;
    ne = (n > MAX_PIX) ? MAX_PIX : n;
    for (int k = 0; k < ne; k++) begin
      exp_addr_q.push_back(ADDR_W'(k));
      for (int b = PIX_W - 1; b >= 0; b--) exp_bit_q.push_back(mem[k][b]);
    end
    f.start_cyc = start_cyc;
    f.npix      = ne;
    exp_done_q.push_back(f);
  endtask

  // ---------------- monitor ----------------
  logic   prev_dout = 1'b0;
  int     rise_cyc = 0;
  int     last_rise = 0;
  int     bits_in_frame = 0;
  int     rd_frame = 0;
  int     done_cnt = 0;
  int     w;
  logic   eb;
  logic [ADDR_W-1:0] ea;
  frame_t fr;

  always @(negedge clk) begin
    if (rst) begin
      prev_dout     = 1'b0;
      bits_in_frame = 0;
      rd_frame      = 0;
    end else begin
      if (pix_rd) begin
        if (exp_addr_q.size() == 0) begin
          fail_now("unexpected_read", pix_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          check("read_addr", pix_addr, ea);
        end
        rd_frame++;
      end
      if (dout && !prev_dout) begin
        check("busy_during_bit", busy, 1);
        if (exp_done_q.size() > 0) begin
          if (bits_in_frame == 0)
            check_range("first_bit_latency", cyc - exp_done_q[0].start_cyc, 3, 44);
          else
            check("bit_period", cyc - last_rise, CYC_COUNT);
          if (bits_in_frame % PIX_W == 0)
            check_range("pixel_read_ahead", rd_frame, bits_in_frame / PIX_W + 1, exp_done_q[0].npix);
        end
        rise_cyc  = cyc;
        last_rise = cyc;
      end
      if (!dout && prev_dout) begin
        w = cyc - rise_cyc;
        if (exp_bit_q.size() == 0) begin
          fail_now("unexpected_pulse", w);
        end else begin
          eb = exp_bit_q.pop_front();
          check("pulse_width", w, eb ? ON_CYC_HI : ZR_CYC_HI);
        end
        bits_in_frame++;
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        if (exp_done_q.size() == 0) begin
          fail_now("unexpected_done", cyc);
        end else begin
          fr = exp_done_q.pop_front();
          if (fr.npix == 0) begin
            check("empty_done_latency", cyc - fr.start_cyc, 1);
          end else begin
            check("latch_gap", cyc - last_rise, (1 + LATCH_SLOTS) * CYC_COUNT);
          end
          check("frame_bits", bits_in_frame, fr.npix * PIX_W);
        end
        done_cnt++;
        bits_in_frame = 0;
        rd_frame      = 0;
      end
      prev_dout = dout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(int n);
    @(posedge clk); #1;
    start      = 1'b1;
    num_pixels = (ADDR_W+1)'(n);
    push_expect(n, cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Raise start during the cycle in which done is high.
  task automatic start_at_done(int n, int budget);
    int t = 0;
    @(negedge clk);
    while (!done && t < budget) begin @(negedge clk); t++; end
    if (!done) begin
      fail_now("wait_for_done_edge", t);
    end else begin
      start      = 1'b1;
      num_pixels = (ADDR_W+1)'(n);
      push_expect(n, cyc);
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(int target, int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin @(negedge clk); t++; end
    if (done_cnt < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: done count %0d expected %0d", done_cnt, target);
    end
  endtask

  task automatic rand_mem(int n);
    for (int k = 0; k < n; k++) mem[k] = PIX_W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int t;
    slot_cnt = 6'($urandom_range(0, CYC_COUNT - 1));
    for (int k = 0; k < MAX_PIX; k++) mem[k] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pix_rd", pix_rd, 0);
    check("reset_pix_addr", pix_addr, 0);
    check("reset_dout", dout, 0);
    check("reset_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;

    // Single pixel with both edge bits set.
    mem[0] = 24'h800001;
    do_start(1);
    wait_done(1, 3000);

    // Three pixels; a start in the middle of SEND must be ignored.
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00FF00;
    mem[2] = 24'h0000FF;
    do_start(3);
    repeat (1500) @(posedge clk);
    #1;
    start      = 1'b1;
    num_pixels = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, 6000);

    // Empty frame.
    do_start(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("empty_busy_low", busy, 0);
    end
    wait_done(3, 100);

    // Reset in the middle of slot 30 while the line is high.
    do_start(3);
    t = 0;
    @(negedge clk);
    while (!(dout && bits_in_frame == 30) && t < 3000) begin @(negedge clk); t++; end
    check("reached_slot30", bits_in_frame, 30);
    #2;
    rst = 1'b1;
    #1;
    check("rst_dout_async", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    exp_bit_q.delete();
    exp_addr_q.delete();
    exp_done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem[0] = 24'h800001;
    do_start(1);
    wait_done(4, 3000);

    // Back-to-back frames: second start lands in the done cycle.
    rand_mem(4);
    do_start(2);
    start_at_done(3, 5000);
    wait_done(6, 6000);

    // Randomised frames, including empty ones.
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 4);
      rand_mem(4);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      do_start(n);
      wait_done(7 + i, 6000);
    end

    repeat (50) @(posedge clk);
    check("leftover_bits", exp_bit_q.size(), 0);
    check("leftover_reads", exp_addr_q.size(), 0);
    check("leftover_frames", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
